// File: rtl/text_pkg.sv
// Shared constants and encodings for the text writer and the display that
// consumes its buffer writes and scroll requests.
//   TEXT_COLS / TEXT_ROWS : character buffer geometry (1024 cells)
//   TEXT_VIS_ROWS         : rows visible on screen at scroll position 0
//   TEXT_BLANK            : glyph code written into erased cells
//   cmd_e                 : producer command encoding
//   state_e               : writer FSM states
//   scroll_e              : scroll request encoding shared with the display
package text_pkg;

    localparam int TEXT_COLS     = 32;
    localparam int TEXT_ROWS     = 32;
    localparam int TEXT_VIS_ROWS = 16;
    localparam int TEXT_ADDR_W   = 10;
    localparam logic [4:0] TEXT_BLANK = 5'd26;

    typedef enum logic [1:0] {
        CMD_CHAR      = 2'd0,
        CMD_BACKSPACE = 2'd1,
        CMD_NEWLINE   = 2'd2,
        CMD_CLEAR     = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_REWIND = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SCROLL_HOLD = 2'd0,
        SCROLL_DOWN = 2'd1,
        SCROLL_UP   = 2'd2
    } scroll_e;

endpackage

// File: rtl/text_writer.sv
// Character-buffer writer. Accepts CHAR / BACKSPACE / NEWLINE / CLEAR
// commands, turns them into single-cell buffer writes, tracks the cursor and
// asks the display to scroll as the cursor moves past the visible area.
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   valid_in, cmd_in,
//   char_in               : command request (accepted when ready_out is high)
//   ready_out             : high while idle
//   wr_valid_out,
//   wr_addr_out,
//   wr_data_out           : one-cycle buffer write (address row*COLS+col)
//   cursor_out            : address of the next cell to be written
//   scroll_dir_out        : 0 hold, 1 scroll down a line, 2 scroll up a line
module text_writer
    import text_pkg::*;
#(
    parameter int         COLS     = TEXT_COLS,
    parameter int         ROWS     = TEXT_ROWS,
    parameter int         VIS_ROWS = TEXT_VIS_ROWS,
    parameter logic [4:0] BLANK    = TEXT_BLANK
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_in,
    input  logic [1:0] cmd_in,
    input  logic [4:0] char_in,
    output logic       ready_out,
    output logic       wr_valid_out,
    output logic [9:0] wr_addr_out,
    output logic [4:0] wr_data_out,
    output logic [9:0] cursor_out,
    output logic [1:0] scroll_dir_out
);

    // Number of scroll-up steps needed to bring row 0 back on screen.
    localparam int         REW_LEN   = ROWS - VIS_ROWS;
    localparam logic [9:0] REW_LAST  = 10'(REW_LEN);
    localparam logic [9:0] LAST_ADDR = 10'd1023;

    state_e     state_q, state_d;
    logic [9:0] cursor_q, cursor_d;
    logic [9:0] cnt_q, cnt_d;          // FILL/CLEAR address, REWIND step count
    logic       wr_valid_q, wr_valid_d;
    logic [9:0] wr_addr_q, wr_addr_d;
    logic [4:0] wr_data_q, wr_data_d;
    logic [1:0] scroll_q, scroll_d;

    logic [9:0] cursor_inc;
    logic [9:0] cursor_dec;

    assign cursor_inc = cursor_q + 10'd1;
    assign cursor_dec = cursor_q - 10'd1;

    function automatic logic row_start(input logic [9:0] a);
        return (32'(a) % COLS) == 0;
    endfunction

    // A cursor landing on column 0 of a row below the visible window needs
    // the display to follow it down one line.
    function automatic logic needs_scroll(input logic [9:0] a);
        int r;
        r = int'(32'(a) / COLS);
        return row_start(a) && (r >= VIS_ROWS) && (r <= ROWS - 1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        cnt_d      = cnt_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        scroll_d   = SCROLL_HOLD;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    case (cmd_e'(cmd_in))
                        CMD_CHAR: begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = cursor_q;
                            wr_data_d  = char_in;
                            cursor_d   = cursor_inc;
                            if (cursor_q == LAST_ADDR) begin
                                state_d = ST_REWIND;
                                cnt_d   = '0;
                            end else if (needs_scroll(cursor_inc)) begin
                                scroll_d = SCROLL_DOWN;
                            end
                        end
                        CMD_BACKSPACE: begin
                            if (cursor_q != '0) begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = cursor_dec;
                                wr_data_d  = BLANK;
                                cursor_d   = cursor_dec;
                            end
                        end
                        CMD_NEWLINE: begin
                            // First blank goes out immediately; FILL carries on
                            // from the following cell.
                            wr_valid_d = 1'b1;
                            wr_addr_d  = cursor_q;
                            wr_data_d  = BLANK;
                            cnt_d      = cursor_inc;
                            state_d    = ST_FILL;
                        end
                        default: begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = '0;
                            wr_data_d  = BLANK;
                            cnt_d      = 10'd1;
                            state_d    = ST_CLEAR;
                        end
                    endcase
                end
            end

            ST_FILL: begin
                if (!row_start(cnt_q)) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = cnt_q;
                    wr_data_d  = BLANK;
                    cnt_d      = cnt_q + 10'd1;
                end else begin
                    // cnt_q already holds the start of the next row (mod 1024).
                    cursor_d = cnt_q;
                    if (cnt_q == '0) begin
                        state_d = ST_REWIND;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        if (needs_scroll(cnt_q)) begin
                            scroll_d = SCROLL_DOWN;
                        end
                    end
                end
            end

            ST_CLEAR: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = cnt_q;
                wr_data_d  = BLANK;
                cnt_d      = cnt_q + 10'd1;
                if (cnt_q == LAST_ADDR) begin
                    cursor_d = '0;
                    state_d  = ST_REWIND;
                    cnt_d    = '0;
                end
            end

            default: begin
                if (cnt_q == REW_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    scroll_d = SCROLL_UP;
                    cnt_d    = cnt_q + 10'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cursor_q   <= '0;
            cnt_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            scroll_q   <= SCROLL_HOLD;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            cnt_q      <= cnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            scroll_q   <= scroll_d;
        end
    end

    assign ready_out      = (state_q == ST_IDLE);
    assign wr_valid_out   = wr_valid_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign cursor_out     = cursor_q;
    assign scroll_dir_out = scroll_q;

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: directed scenarios with literal expectations plus a
// randomized command stream. A reference model expands every accepted command
// into the per-cycle output sequence it must produce; a compare process checks
// the DUT against that sequence on every cycle.
module tb_text_writer;
    import text_pkg::*;

    logic       clk_in   = 1'b0;
    logic       rst_in   = 1'b1;
    logic       valid_in = 1'b0;
    logic [1:0] cmd_in   = 2'd0;
    logic [4:0] char_in  = 5'd0;
    logic       ready_out;
    logic       wr_valid_out;
    logic [9:0] wr_addr_out;
    logic [4:0] wr_data_out;
    logic [9:0] cursor_out;
    logic [1:0] scroll_dir_out;

    text_writer dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .cmd_in        (cmd_in),
        .char_in       (char_in),
        .ready_out     (ready_out),
        .wr_valid_out  (wr_valid_out),
        .wr_addr_out   (wr_addr_out),
        .wr_data_out   (wr_data_out),
        .cursor_out    (cursor_out),
        .scroll_dir_out(scroll_dir_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       wv;
        logic [9:0] addr;
        logic [4:0] data;
        logic [9:0] cur;
        logic [1:0] scr;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   mcur  = 0;
    bit   armed = 1'b0;

    localparam int NCELL = TEXT_COLS * TEXT_ROWS;
    localparam int NREW  = TEXT_ROWS - TEXT_VIS_ROWS;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t mk(input int wv, input int addr, input int data,
                                input int cur, input int scr, input int rdy);
        exp_t e;
        e.wv   = 1'(wv);
        e.addr = 10'(addr);
        e.data = 5'(data);
        e.cur  = 10'(cur);
        e.scr  = 2'(scr);
        e.rdy  = 1'(rdy);
        return e;
    endfunction

    // Scroll request when the cursor arrives at the start of a row below the
    // visible window.
    function automatic int adv_scroll(input int n);
        int r;
        r = n / TEXT_COLS;
        if ((n % TEXT_COLS) == 0 && r >= TEXT_VIS_ROWS && r <= TEXT_ROWS - 1) return 1;
        return 0;
    endfunction

    task automatic push_rewind();
        for (int i = 0; i < NREW; i++) exp_q.push_back(mk(0, 0, 0, 0, 2, 0));
    endtask

    task automatic expand(input int cmd, input int ch);
        int c, n, r;
        c = mcur;
        case (cmd)
            0: begin
                n = (c + 1) % NCELL;
                exp_q.push_back(mk(1, c, ch, n, (n == 0) ? 0 : adv_scroll(n), (n != 0) ? 1 : 0));
                if (n == 0) push_rewind();
            end
            1: begin
                if (c > 0) exp_q.push_back(mk(1, c - 1, int'(TEXT_BLANK), c - 1, 0, 1));
                else       exp_q.push_back(mk(0, 0, 0, c, 0, 1));
            end
            2: begin
                r = c / TEXT_COLS;
                for (int a = c; a <= r * TEXT_COLS + TEXT_COLS - 1; a++)
                    exp_q.push_back(mk(1, a, int'(TEXT_BLANK), c, 0, 0));
                n = ((r + 1) * TEXT_COLS) % NCELL;
                exp_q.push_back(mk(0, 0, 0, n, (n == 0) ? 0 : adv_scroll(n), (n != 0) ? 1 : 0));
                if (n == 0) push_rewind();
            end
            default: begin
                for (int a = 0; a < NCELL; a++)
                    exp_q.push_back(mk(1, a, int'(TEXT_BLANK), (a == NCELL - 1) ? 0 : c, 0, 0));
                push_rewind();
            end
        endcase
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        exp_t e;
        e = mk(0, 0, 0, mcur, 0, 1);
        if (armed) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            mcur = int'(e.cur);
            n_checks++;
            if (wr_valid_out !== e.wv || cursor_out !== e.cur || scroll_dir_out !== e.scr ||
                ready_out !== e.rdy ||
                (e.wv && (wr_addr_out !== e.addr || wr_data_out !== e.data))) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got wv=%0b addr=%0d data=%0d cur=%0d scr=%0d rdy=%0b expected wv=%0b addr=%0d data=%0d cur=%0d scr=%0d rdy=%0b",
                         $time, wr_valid_out, wr_addr_out, wr_data_out, cursor_out,
                         scroll_dir_out, ready_out, e.wv, e.addr, e.data, e.cur, e.scr, e.rdy);
            end
        end
        if (rst_in) begin
            exp_q.delete();
            mcur  = 0;
            armed = 1'b1;
        end else if (armed && e.rdy && valid_in) begin
            expand(int'(cmd_in), int'(char_in));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        step();
        rst_in = 1'b0;
    endtask

    // Holds the request until accepted; returns one tick after the accepting edge.
    task automatic send(input logic [1:0] cmd, input logic [4:0] ch);
        int   n;
        logic r;
        cmd_in   = cmd;
        char_in  = ch;
        valid_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            r = ready_out;
            step();
            n++;
        end while (!r && n < 3000);
        valid_in = 1'b0;
        if (!r) chk("send_timeout", 0, 1);
    endtask

    task automatic goto_cursor(input int target);
        do_reset();
        repeat (target / TEXT_COLS) send(CMD_NEWLINE, 5'd0);
        repeat (target % TEXT_COLS) send(CMD_CHAR, 5'($urandom_range(0, 31)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int writes, ups, nxt, i;

        // Reset state.
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("rst_ready", int'(ready_out), 1);
        chk("rst_wr_valid", int'(wr_valid_out), 0);
        chk("rst_wr_addr", int'(wr_addr_out), 0);
        chk("rst_wr_data", int'(wr_data_out), 0);
        chk("rst_cursor", int'(cursor_out), 0);
        chk("rst_scroll", int'(scroll_dir_out), 0);

        // Back-to-back characters.
        for (int k = 0; k < 3; k++) begin
            send(CMD_CHAR, 5'(k));
            chk("abc_wv", int'(wr_valid_out), 1);
            chk("abc_addr", int'(wr_addr_out), k);
            chk("abc_data", int'(wr_data_out), k);
            chk("abc_ready", int'(ready_out), 1);
        end
        chk("abc_cursor", int'(cursor_out), 3);

        // Backspace from 5 and from 0.
        goto_cursor(5);
        send(CMD_BACKSPACE, 5'd0);
        chk("bs_wv", int'(wr_valid_out), 1);
        chk("bs_addr", int'(wr_addr_out), 4);
        chk("bs_data", int'(wr_data_out), 26);
        chk("bs_cursor", int'(cursor_out), 4);
        do_reset();
        send(CMD_BACKSPACE, 5'd0);
        chk("bs0_wv", int'(wr_valid_out), 0);
        chk("bs0_cursor", int'(cursor_out), 0);

        // Newline from column 30.
        goto_cursor(30);
        send(CMD_NEWLINE, 5'd0);
        chk("nl30_addr0", int'(wr_addr_out), 30);
        chk("nl30_ready0", int'(ready_out), 0);
        step();
        chk("nl30_addr1", int'(wr_addr_out), 31);
        chk("nl30_data1", int'(wr_data_out), 26);
        chk("nl30_ready1", int'(ready_out), 0);
        step();
        chk("nl30_ready2", int'(ready_out), 1);
        chk("nl30_cursor", int'(cursor_out), 32);
        chk("nl30_scroll", int'(scroll_dir_out), 0);

        // Newline from row 15 col 7 crosses into the first off-screen row.
        goto_cursor(15 * 32 + 7);
        send(CMD_NEWLINE, 5'd0);
        writes = 0;
        i = 0;
        while (!ready_out && i < 100) begin
            if (wr_valid_out) writes++;
            step();
            i++;
        end
        chk("nl487_writes", writes, 25);
        chk("nl487_cursor", int'(cursor_out), 512);
        chk("nl487_scroll", int'(scroll_dir_out), 1);
        step();
        chk("nl487_scroll_after", int'(scroll_dir_out), 0);

        // Character at the last cell wraps and rewinds.
        goto_cursor(1023);
        send(CMD_CHAR, 5'd4);
        chk("wrap_addr", int'(wr_addr_out), 1023);
        chk("wrap_data", int'(wr_data_out), 4);
        chk("wrap_cursor", int'(cursor_out), 0);
        step();
        ups = 0;
        i = 0;
        while (!ready_out && i < 100) begin
            if (scroll_dir_out == 2'd2) ups++;
            step();
            i++;
        end
        chk("wrap_rewind_len", ups, 16);

        // Full clear.
        send(CMD_CLEAR, 5'd0);
        writes = 0;
        ups = 0;
        nxt = 0;
        i = 0;
        while (!ready_out && i < 2000) begin
            if (wr_valid_out && wr_data_out == 5'd26 && int'(wr_addr_out) == nxt) begin
                writes++;
                nxt++;
            end
            if (scroll_dir_out == 2'd2) ups++;
            step();
            i++;
        end
        chk("clr_writes", writes, 1024);
        chk("clr_rewind_len", ups, 16);
        chk("clr_cursor", int'(cursor_out), 0);

        // Reset in the middle of a clear.
        send(CMD_CHAR, 5'd9);
        send(CMD_CLEAR, 5'd0);
        repeat (500) step();
        chk("clrrst_addr", int'(wr_addr_out), 500);
        do_reset();
        chk("clrrst_wv", int'(wr_valid_out), 0);
        chk("clrrst_cursor", int'(cursor_out), 0);
        chk("clrrst_ready", int'(ready_out), 1);
        step();
        chk("clrrst_wv_later", int'(wr_valid_out), 0);

        // Randomized stream.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            int p;
            p = int'($urandom_range(0, 99));
            if (p < 55)      send(CMD_CHAR, 5'($urandom_range(0, 31)));
            else if (p < 70) send(CMD_BACKSPACE, 5'($urandom_range(0, 31)));
            else if (p < 96) send(CMD_NEWLINE, 5'($urandom_range(0, 31)));
            else if (p < 98) send(CMD_CLEAR, 5'd0);
            else begin
                repeat ($urandom_range(0, 20)) step();
                do_reset();
            end
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
